imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 134 +++++++++++++
 tb/tb_imem_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction memory with a streaming loader (IDLE/LOAD/RUN) and a one-cycle registered fetch port.
// Define IMEM_PARITY_EN to store an even-parity bit per word and report mismatches on parity_err.
module imem_loader #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic        ld_last,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic        ld_done,
    input  logic        fetch_en,
    input  logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        fault,
    output logic        parity_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]    r_state;
    logic [AW-1:0] r_ptr;
    logic          r_ld_done;
    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_instr;
    logic          r_instr_valid;
    logic          r_fault;

    logic          w_beat;
    logic          w_ptr_top;
    logic          w_end;
    logic          w_fetch;
    logic          w_fault;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rdata;

    assign w_beat    = (r_state == ST_LOAD) && ld_valid;
    assign w_ptr_top = (r_ptr == AW'(DEPTH - 1));
    assign w_end     = w_beat && (ld_last || w_ptr_top);

    assign w_fetch = (r_state == ST_RUN) && fetch_en;
    assign w_fault = (pc[1:0] != 2'b00) || (pc[31:2] >= 30'(DEPTH));
    assign w_idx   = pc[AW+1:2];
    assign w_rdata = r_mem[w_idx];

    assign ld_ready    = (r_state == ST_LOAD);
    assign busy        = (r_state == ST_LOAD);
    assign ld_done     = r_ld_done;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign fault       = r_fault;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_ld_done <= 1'b0;
        end else begin
            r_ld_done <= w_end;
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (ld_start) begin
                        r_state <= ST_LOAD;
                        r_ptr   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_end) begin
                        r_state <= ST_RUN;
                    end
                    // Saturate at the last word so the pointer can never wrap back to 0.
                    if (w_beat && !w_ptr_top) begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Storage is deliberately outside reset: contents survive reset and new sessions.
    always_ff @(posedge clock) begin
        if (w_beat) begin
            r_mem[r_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_instr_valid <= w_fetch;
            r_fault       <= w_fetch && w_fault;
            if (w_fetch) begin
                r_instr <= w_fault ? NOP_INSTR : w_rdata;
            end
        end
    end

`ifdef IMEM_PARITY_EN
    logic r_par [DEPTH];
    logic r_parity_err;

    always_ff @(posedge clock) begin
        if (w_beat) begin
            r_par[r_ptr] <= ^ld_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_fetch && !w_fault && (r_par[w_idx] != ^w_rdata);
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized loads/fetches vs. an array model.
module tb_imem_loader;

    localparam int          DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ld_start, ld_valid, ld_last;
    logic [31:0] ld_data;
    logic        ld_ready, ld_done;
    logic        fetch_en;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid, fault, parity_err, busy;

    imem_loader #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clock(clock), .reset_n(reset_n),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_last(ld_last), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done),
        .fetch_en(fetch_en), .pc(pc),
        .instr(instr), .instr_valid(instr_valid), .fault(fault),
        .parity_err(parity_err), .busy(busy)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_mem [DEPTH];
    int          m_ptr;
    logic [31:0] exp_instr;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        m_ptr = 0;
    endtask

    task automatic beat(input logic [31:0] d, input bit last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        step();
        m_mem[m_ptr] = d;
        if (m_ptr < DEPTH - 1) m_ptr++;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch1(input logic [31:0] a);
        fetch_en = 1'b1;
        pc = a;
        step();
        fetch_en = 1'b0;
    endtask

    // Returns {fault, instr} from the addressing rules alone.
    function automatic logic [32:0] ref_fetch(input logic [31:0] a);
        int idx;
        if (a[1:0] != 2'b00 || (a >> 2) >= DEPTH) return {1'b1, NOP};
        idx = int'(a >> 2);
        return {1'b0, m_mem[idx]};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = '0;
        fetch_en = 0; pc = '0;
        #12;
        n_checks++; if (ld_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ld_ready: got %b want 0", ld_ready); end
        n_checks++; if (ld_done !== 1'b0) begin n_errors++; $display("FAIL rst_ld_done: got %b want 0", ld_done); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        n_checks++; if (instr !== NOP) begin n_errors++; $display("FAIL rst_instr: got %h want %h", instr, NOP); end
        n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL rst_fault: got %b want 0", fault); end
        n_checks++; if (parity_err !== 1'b0) begin n_errors++; $display("FAIL rst_parity: got %b want 0", parity_err); end
        step();
        reset_n = 1'b1;
        exp_instr = NOP;
        fetch_en = 1'b1; pc = 32'h0;
        step();
        fetch_en = 1'b0;
        n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL idle_fetch: got %b want 0", instr_valid); end
    endtask

    task automatic test_load_fetch();
        logic [31:0] w [4];
        w[0] = 32'h00A200B3; w[1] = 32'h40120133; w[2] = 32'h00000013; w[3] = 32'hDEADBEEF;
        start_load();
        n_checks++; if (busy !== 1'b1 || ld_ready !== 1'b1) begin n_errors++; $display("FAIL load_enter: got busy=%b ready=%b want 1/1", busy, ld_ready); end
        for (int i = 0; i < 4; i++) begin
            beat(w[i], i == 3);
            n_checks++; if (ld_done !== (i == 3)) begin n_errors++; $display("FAIL load_done_beat%0d: got %b want %b", i, ld_done, i == 3); end
        end
        n_checks++; if (ld_ready !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL load_exit: got ready=%b busy=%b want 0/0", ld_ready, busy); end
        step();
        n_checks++; if (ld_done !== 1'b0) begin n_errors++; $display("FAIL load_done_pulse: got %b want 0", ld_done); end
        fetch1(32'd4);
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h40120133 || fault !== 1'b0) begin n_errors++; $display("FAIL fetch_pc4: got v=%b i=%h f=%b want 1/40120133/0", instr_valid, instr, fault); end
        exp_instr = 32'h40120133;
        step();
        n_checks++; if (instr_valid !== 1'b0 || instr !== exp_instr || fault !== 1'b0) begin n_errors++; $display("FAIL fetch_hold: got v=%b i=%h f=%b want 0/%h/0", instr_valid, instr, fault, exp_instr); end
    endtask

    task automatic test_fault();
        logic [31:0] addrs [5];
        logic [32:0] e;
        addrs[0] = 32'd6; addrs[1] = 32'(4 * DEPTH); addrs[2] = 32'hFFFFFFFC;
        addrs[3] = 32'd1; addrs[4] = 32'd12;
        for (int i = 0; i < 5; i++) begin
            e = ref_fetch(addrs[i]);
            fetch1(addrs[i]);
            n_checks++; if (instr_valid !== 1'b1 || fault !== e[32] || instr !== e[31:0] || parity_err !== 1'b0) begin n_errors++; $display("FAIL fault_pc_%h: got v=%b f=%b i=%h p=%b want 1/%b/%h/0", addrs[i], instr_valid, fault, instr, parity_err, e[32], e[31:0]); end
            exp_instr = e[31:0];
        end
        step();
        n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL fault_clear: got %b want 0", fault); end
    endtask

    task automatic test_full_load();
        int done_cnt = 0;
        start_load();
        for (int i = 0; i < DEPTH; i++) begin
            beat($urandom, 1'b0);
            if (ld_done === 1'b1) done_cnt++;
            if (i < DEPTH - 1) begin
                n_checks++; if (ld_ready !== 1'b1 || ld_done !== 1'b0) begin n_errors++; $display("FAIL full_mid%0d: got ready=%b done=%b want 1/0", i, ld_ready, ld_done); end
            end
        end
        n_checks++; if (ld_ready !== 1'b0 || busy !== 1'b0 || ld_done !== 1'b1) begin n_errors++; $display("FAIL full_end: got ready=%b busy=%b done=%b want 0/0/1", ld_ready, busy, ld_done); end
        ld_valid = 1'b1; ld_last = 1'b1; ld_data = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (ld_done === 1'b1) done_cnt++;
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL full_done_count: got %0d want 1", done_cnt); end
        fetch_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            int idx;
            idx = (i * 7 + 3) % DEPTH;
            pc = 32'(idx * 4);
            step();
            n_checks++; if (instr_valid !== 1'b1 || instr !== m_mem[idx] || fault !== 1'b0) begin n_errors++; $display("FAIL full_read%0d: got v=%b i=%h f=%b want 1/%h/0", idx, instr_valid, instr, fault, m_mem[idx]); end
            exp_instr = m_mem[idx];
        end
        fetch_en = 1'b0;
        step();
        n_checks++; if (instr_valid !== 1'b0 || instr !== exp_instr) begin n_errors++; $display("FAIL full_idle: got v=%b i=%h want 0/%h", instr_valid, instr, exp_instr); end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] a0, a1, b0;
        int done_seen = 0;
        a0 = $urandom; a1 = $urandom; b0 = $urandom;
        start_load();
        beat(a0, 1'b0);
        beat(a1, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || ld_ready !== 1'b0 || ld_done !== 1'b0) begin n_errors++; $display("FAIL abort_now: got busy=%b ready=%b done=%b want 0/0/0", busy, ld_ready, ld_done); end
        n_checks++; if (instr !== NOP || instr_valid !== 1'b0 || fault !== 1'b0) begin n_errors++; $display("FAIL abort_out: got i=%h v=%b f=%b want %h/0/0", instr, instr_valid, fault, NOP); end
        exp_instr = NOP;
        step();
        if (ld_done === 1'b1) done_seen++;
        reset_n = 1'b1;
        fetch_en = 1'b1; pc = 32'h0;
        step();
        fetch_en = 1'b0;
        if (ld_done === 1'b1) done_seen++;
        n_checks++; if (done_seen !== 0 || instr_valid !== 1'b0) begin n_errors++; $display("FAIL abort_idle: got done=%0d v=%b want 0/0", done_seen, instr_valid); end
        start_load();
        beat(b0, 1'b1);
        n_checks++; if (ld_done !== 1'b1) begin n_errors++; $display("FAIL reload_done: got %b want 1", ld_done); end
        fetch1(32'd0);
        n_checks++; if (instr !== b0 || instr_valid !== 1'b1) begin n_errors++; $display("FAIL reload_pc0: got %h v=%b want %h/1", instr, instr_valid, b0); end
        fetch1(32'd4);
        n_checks++; if (instr !== a1) begin n_errors++; $display("FAIL retained_pc4: got %h want %h", instr, a1); end
        exp_instr = a1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        fetch_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = 32'(i * 4);
            step();
            n_checks++; if (instr_valid !== 1'b1 || instr !== m_mem[i]) begin n_errors++; $display("FAIL b2b_%0d: got v=%b i=%h want 1/%h", i, instr_valid, instr, m_mem[i]); end
            exp_instr = m_mem[i];
        end
        fetch_en = 1'b0;
        start_load();
        fetch_en = 1'b1; pc = 32'd4;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++; if (instr_valid !== 1'b0 || instr !== exp_instr) begin n_errors++; $display("FAIL load_fetch%0d: got v=%b i=%h want 0/%h", i, instr_valid, instr, exp_instr); end
        end
        fetch_en = 1'b0;
        d = $urandom;
        beat(d, 1'b1);
        n_checks++; if (ld_done !== 1'b1) begin n_errors++; $display("FAIL b2b_reload_done: got %b want 1", ld_done); end
    endtask

    task automatic test_parity();
        logic exp_p;
`ifdef IMEM_PARITY_EN
        exp_p = 1'b1;
`else
        exp_p = 1'b0;
`endif
        fetch1(32'd8);
        n_checks++; if (parity_err !== 1'b0 || instr !== m_mem[2]) begin n_errors++; $display("FAIL parity_clean: got p=%b i=%h want 0/%h", parity_err, instr, m_mem[2]); end
        dut.r_mem[2] = dut.r_mem[2] ^ 32'h00000020;
        m_mem[2] = m_mem[2] ^ 32'h00000020;
        fetch1(32'd8);
        n_checks++; if (parity_err !== exp_p || instr !== m_mem[2] || instr_valid !== 1'b1) begin n_errors++; $display("FAIL parity_flip: got p=%b i=%h v=%b want %b/%h/1", parity_err, instr, instr_valid, exp_p, m_mem[2]); end
        step();
        n_checks++; if (parity_err !== 1'b0) begin n_errors++; $display("FAIL parity_idle: got %b want 0", parity_err); end
        dut.r_mem[2] = dut.r_mem[2] ^ 32'h00000020;
        m_mem[2] = m_mem[2] ^ 32'h00000020;
        exp_instr = instr;
    endtask

    task automatic test_random();
        for (int s = 0; s < 12; s++) begin
            int len, n;
            len = $urandom_range(1, DEPTH);
            n = 0;
            start_load();
            while (n < len) begin
                bit v;
                v = ($urandom % 3) != 0;
                ld_valid = v;
                ld_data  = $urandom;
                ld_start = ($urandom % 4) == 0;
                ld_last  = v ? (n == len - 1 && len < DEPTH) : 1'($urandom % 2);
                step();
                if (v) begin
                    m_mem[m_ptr] = ld_data;
                    if (m_ptr < DEPTH - 1) m_ptr++;
                    n++;
                end
                n_checks++; if (ld_done !== (v && n == len) || busy !== (n < len)) begin n_errors++; $display("FAIL rnd_load%0d: got done=%b busy=%b want %b/%b", s, ld_done, busy, v && n == len, n < len); end
            end
            ld_valid = 0; ld_last = 0; ld_start = 0;
            for (int c = 0; c < 20; c++) begin
                bit fe;
                logic [32:0] e;
                int kind;
                fe = $urandom % 4 != 0;
                kind = $urandom % 4;
                if (kind == 1) begin
                    pc = $urandom % (4 * DEPTH);
                    if (pc[1:0] == 2'b00) pc = pc | 32'd2;
                end else if (kind == 2) begin
                    pc = ($urandom | 32'h00001000) & 32'hFFFFFFFC;
                end else begin
                    pc = 32'($urandom_range(0, DEPTH - 1) * 4);
                end
                fetch_en = fe;
                e = ref_fetch(pc);
                step();
                if (fe) begin
                    exp_instr = e[31:0];
                    n_checks++; if (instr_valid !== 1'b1 || fault !== e[32] || instr !== e[31:0] || parity_err !== 1'b0) begin n_errors++; $display("FAIL rnd_fetch%0d_%0d: got v=%b f=%b i=%h p=%b want 1/%b/%h/0", s, c, instr_valid, fault, instr, parity_err, e[32], e[31:0]); end
                end else begin
                    n_checks++; if (instr_valid !== 1'b0 || fault !== 1'b0 || parity_err !== 1'b0 || instr !== exp_instr) begin n_errors++; $display("FAIL rnd_idle%0d_%0d: got v=%b f=%b p=%b i=%h want 0/0/0/%h", s, c, instr_valid, fault, parity_err, instr, exp_instr); end
                end
            end
            fetch_en = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_fault();
        test_full_load();
        test_reset_mid_load();
        test_back_to_back();
        test_parity();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
